// File: rtl/instr_fetch_unit.sv
// Byte-serial x86-subset instruction fetcher and length decoder.
// Latency: N+1 cycles from accepted start to fetch_done for an N-byte instruction, plus one cycle per memory wait state.
// Backpressure: mem_req/mem_addr hold until mem_ack; start is ignored while busy; abort cancels with no fetch_done.
//
// Ports:
//   clock, reset_n                 - single clock, async active-low reset
//   start, eip, abort              - fetch request at eip / cancel in-flight fetch
//   mem_req, mem_addr, mem_rdata,
//   mem_ack                        - byte memory read port, one byte per ack
//   busy, fetch_done               - any non-IDLE state / one-cycle result strobe
//   num_of_ope, instr_bytes,
//   illegal                        - decoded length (1-6), assembled bytes, unsupported encoding
module instr_fetch_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] eip,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        fetch_done,
    output logic [3:0]  num_of_ope,
    output logic [47:0] instr_bytes,
    output logic        illegal
);

    typedef enum logic [2:0] {IDLE, OPC, MODRM, REST, DONE} state_t;

    state_t     state;
    logic [2:0] idx;        // index of the byte currently requested
    logic [2:0] len;        // total length once known (REST only)

    // Opcode decode of the byte arriving in OPC
    logic [2:0] opc_len;
    logic       opc_modrm;
    logic       opc_ill;

    always_comb begin
        opc_len   = 3'd1;
        opc_modrm = 1'b0;
        opc_ill   = 1'b0;
        if (mem_rdata inside {[8'h40:8'h5F], 8'h90, 8'hC3})
            opc_len = 3'd1;
        else if (mem_rdata inside {[8'h70:8'h7F], 8'hEB, [8'hB0:8'hB7]})
            opc_len = 3'd2;
        else if (mem_rdata inside {8'h05, [8'hB8:8'hBF], 8'hE8, 8'hE9})
            opc_len = 3'd5;
        else if (mem_rdata inside {8'h01, 8'h03, 8'h29, 8'h2B, 8'h31,
                                   8'h33, 8'h39, 8'h3B, 8'h89, 8'h8B})
            opc_modrm = 1'b1;
        else
            opc_ill = 1'b1;
    end

    // ModRM decode of the byte arriving in MODRM; SIB forms are not supported
    logic [2:0] mrm_len;
    logic       mrm_ill;

    always_comb begin
        mrm_len = 3'd2;
        mrm_ill = 1'b0;
        case (mem_rdata[7:6])
            2'b11:   mrm_len = 3'd2;
            2'b01:   mrm_len = 3'd3;
            2'b10:   mrm_len = 3'd6;
            default: begin
                if (mem_rdata[2:0] == 3'b101)
                    mrm_len = 3'd6;
                else if (mem_rdata[2:0] == 3'b100)
                    mrm_ill = 1'b1;
            end
        endcase
    end

    assign busy       = (state != IDLE);
    assign fetch_done = (state == DONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= 3'd0;
            len         <= 3'd0;
            mem_req     <= 1'b0;
            mem_addr    <= 32'd0;
            num_of_ope  <= 4'd0;
            instr_bytes <= 48'd0;
            illegal     <= 1'b0;
        end else if (state != IDLE && abort) begin
            // Abort beats a coincident mem_ack: the byte is dropped.
            state   <= IDLE;
            mem_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= OPC;
                        mem_req     <= 1'b1;
                        mem_addr    <= eip;
                        idx         <= 3'd0;
                        instr_bytes <= 48'd0;
                        illegal     <= 1'b0;
                    end
                end
                OPC: begin
                    if (mem_ack) begin
                        instr_bytes[7:0] <= mem_rdata;
                        if (opc_modrm) begin
                            state    <= MODRM;
                            idx      <= 3'd1;
                            mem_addr <= mem_addr + 32'd1;
                        end else if (opc_len == 3'd1) begin
                            // Single-byte and illegal opcodes both finish here
                            state      <= DONE;
                            mem_req    <= 1'b0;
                            illegal    <= opc_ill;
                            num_of_ope <= 4'd1;
                        end else begin
                            state    <= REST;
                            len      <= opc_len;
                            idx      <= 3'd1;
                            mem_addr <= mem_addr + 32'd1;
                        end
                    end
                end
                MODRM: begin
                    if (mem_ack) begin
                        instr_bytes[15:8] <= mem_rdata;
                        illegal           <= mrm_ill;
                        if (mrm_len == 3'd2) begin
                            state      <= DONE;
                            mem_req    <= 1'b0;
                            num_of_ope <= 4'd2;
                        end else begin
                            state    <= REST;
                            len      <= mrm_len;
                            idx      <= 3'd2;
                            mem_addr <= mem_addr + 32'd1;
                        end
                    end
                end
                REST: begin
                    if (mem_ack) begin
                        instr_bytes[8*idx +: 8] <= mem_rdata;
                        if (idx == len - 3'd1) begin
                            state      <= DONE;
                            mem_req    <= 1'b0;
                            num_of_ope <= {1'b0, len};
                        end else begin
                            idx      <= idx + 3'd1;
                            mem_addr <= mem_addr + 32'd1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [31:0] eip;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        fetch_done;
    logic [3:0]  num_of_ope;
    logic [47:0] instr_bytes;
    logic        illegal;

    instr_fetch_unit dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .eip         (eip),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .busy        (busy),
        .fetch_done  (fetch_done),
        .num_of_ope  (num_of_ope),
        .instr_bytes (instr_bytes),
        .illegal     (illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] eip;
        logic [47:0] img;       // memory contents from eip, byte 0 in [7:0]
        int          nb;
        logic [3:0]  len;
        logic        ill;
        logic [47:0] bytes;
        int          done_cyc;  // cycles after the start edge
        int          wait_byte; // byte index that gets wait states (-1: none)
        int          wait_n;
        int          bs_cyc;    // cycle to pulse a stray start (0: none)
    } vec_t;

    typedef struct {
        logic [3:0]  len;
        logic        ill;
        logic [47:0] bytes;
        int          cyc;
    } exp_t;

    logic [7:0]  mem [logic [31:0]];
    exp_t        exp_q [$];
    logic [31:0] addr_q [$];
    vec_t        vecs [13];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] e, input logic [47:0] img, input int nb,
                                input logic [3:0] len, input logic ill, input logic [47:0] bytes,
                                input int dc, input int wb, input int wn, input int bs);
        vec_t v;
        v.eip = e; v.img = img; v.nb = nb; v.len = len; v.ill = ill; v.bytes = bytes;
        v.done_cyc = dc; v.wait_byte = wb; v.wait_n = wn; v.bs_cyc = bs;
        return v;
    endfunction

    task automatic load_mem(input logic [31:0] base, input logic [47:0] img, input int nb);
        for (int i = 0; i < nb; i++) mem[base + 32'(i)] = img[8*i +: 8];
    endtask

    task automatic start_fetch(input logic [31:0] e);
        @(negedge clock);
        start = 1'b1;
        eip   = e;
        @(negedge clock);   // now in cycle T+1
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   k, waits, cyc;
        bit   done;
        load_mem(v.eip, v.img, v.nb);
        e.len = v.len; e.ill = v.ill; e.bytes = v.bytes; e.cyc = v.done_cyc;
        exp_q.push_back(e);
        for (int i = 0; i < int'(v.len); i++) addr_q.push_back(v.eip + 32'(i));
        start_fetch(v.eip);
        cyc = 1; k = 0; waits = v.wait_n; done = 1'b0;
        while (!done && cyc < 60) begin
            mem_ack = 1'b0;
            start   = (cyc == v.bs_cyc);
            if (cyc == v.bs_cyc) eip = 32'hDEAD0000;
            if (fetch_done) begin
                e = exp_q.pop_front();
                chk("num_of_ope", 64'(num_of_ope), 64'(e.len));
                chk("illegal", 64'(illegal), 64'(e.ill));
                chk("instr_bytes", 64'(instr_bytes), 64'(e.bytes));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("missing_reqs", 64'(addr_q.size()), 64'd0);
                done = 1'b1;
            end else if (mem_req) begin
                if (k == v.wait_byte && waits > 0) begin
                    waits--;
                end else if (addr_q.size() == 0) begin
                    chk("extra_req", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    mem_ack = 1'b1;
                    k++;
                end else begin
                    chk("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
                    mem_ack   = 1'b1;
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
                    k++;
                end
            end
            if (!done) begin
                @(negedge clock);
                cyc++;
            end
        end
        mem_ack = 1'b0;
        start   = 1'b0;
        if (!done) begin
            chk("done_timeout", 64'(cyc), 64'(v.done_cyc));
            exp_q.delete();
            addr_q.delete();
        end
        @(negedge clock);
        chk("idle_after_done", 64'({busy, fetch_done}), 64'd0);
        chk("num_of_ope_hold", 64'(num_of_ope), 64'(v.len));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen_done;

        vecs[0]  = mk(32'h50,       48'h90,           1, 4'd1, 1'b0, 48'h90,           2, -1, 0, 0);
        vecs[1]  = mk(32'h60,       48'h00000010858B, 6, 4'd6, 1'b0, 48'h00000010858B, 7, -1, 0, 4);
        vecs[2]  = mk(32'hFFFFFFFE, 48'h0044332211E8, 5, 4'd5, 1'b0, 48'h0044332211E8, 8,  2, 2, 0);
        vecs[3]  = mk(32'h100,      48'h0F,           1, 4'd1, 1'b1, 48'h0F,           2, -1, 0, 0);
        vecs[4]  = mk(32'h200,      48'h0401,         2, 4'd2, 1'b1, 48'h0401,         3, -1, 0, 0);
        vecs[5]  = mk(32'h300,      48'h7AB0,         2, 4'd2, 1'b0, 48'h7AB0,         3, -1, 0, 0);
        vecs[6]  = mk(32'h400,      48'h084501,       3, 4'd3, 1'b0, 48'h084501,       4, -1, 0, 0);
        vecs[7]  = mk(32'h500,      48'hC889,         2, 4'd2, 1'b0, 48'hC889,         3, -1, 0, 0);
        vecs[8]  = mk(32'h600,      48'hDDCCBBAA05,   5, 4'd5, 1'b0, 48'hDDCCBBAA05,   7,  0, 1, 0);
        vecs[9]  = mk(32'h700,      48'h04030201808B, 6, 4'd6, 1'b0, 48'h04030201808B, 7, -1, 0, 0);
        vecs[10] = mk(32'h800,      48'h1075,         2, 4'd2, 1'b0, 48'h1075,         3, -1, 0, 0);
        vecs[11] = mk(32'h900,      48'hC3,           1, 4'd1, 1'b0, 48'hC3,           2, -1, 0, 0);
        vecs[12] = mk(32'hA00,      48'h0031,         2, 4'd2, 1'b0, 48'h0031,         3, -1, 0, 0);

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; eip = 32'd0;
        mem_rdata = 8'h00; mem_ack = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_state", 64'({mem_req, busy, fetch_done, illegal, num_of_ope}), 64'd0);
        chk("reset_addr_bytes", 64'(mem_addr) | 64'(instr_bytes), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Abort coincident with the ack of byte 1 of a 5-byte mov
        load_mem(32'hB00, 48'h04030201B8, 5);
        start_fetch(32'hB00);
        chk("abort_req0", 64'({mem_req, mem_addr}), {31'd0, 1'b1, 32'hB00});
        mem_ack = 1'b1; mem_rdata = 8'hB8;
        @(negedge clock);
        chk("abort_req1", 64'({mem_req, mem_addr}), {31'd0, 1'b1, 32'hB01});
        mem_ack = 1'b1; mem_rdata = 8'h01; abort = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0; abort = 1'b0;
        chk("abort_idle", 64'({busy, mem_req}), 64'd0);
        seen_done = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (fetch_done || busy) seen_done = 1'b1;
        end
        chk("abort_no_done", 64'(seen_done), 64'd0);

        // Asynchronous reset in the middle of REST
        load_mem(32'hC00, 48'h44332211E9, 5);
        start_fetch(32'hC00);
        mem_ack = 1'b1; mem_rdata = 8'hE9;
        @(negedge clock);
        mem_ack = 1'b1; mem_rdata = 8'h11;
        @(negedge clock);
        mem_ack = 1'b0;
        chk("rst_pre_req", 64'({busy, mem_req}), 64'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", 64'({mem_req, busy, fetch_done, illegal, num_of_ope}), 64'd0);
        chk("rst_mid_addr", 64'(mem_addr), 64'd0);
        chk("rst_mid_bytes", 64'(instr_bytes), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_vec(vecs[8]);

        // Stray ack while idle must not start anything
        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        @(negedge clock);
        chk("idle_ack_ignored", 64'({busy, mem_req, fetch_done}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
